// File: rtl/nios_cpu_div_cell.sv
// nios_cpu_div_cell: iterative radix-2 restoring divider for the Nios M stage.
// Takes a dividend/divisor pair on a start pulse and returns the quotient,
// the remainder and a divide-by-zero flag after WIDTH+2 cycles. A one-cycle
// done pulse marks completion. The CPU stalls on busy.
// Optional build macro NIOS_DIV_CELL_ZERO_FASTPATH_EN: a zero divisor skips
// the iteration and completes one cycle after the start is accepted.
module nios_cpu_div_cell #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M_div_start,
  input  logic             M_div_signed,
  input  logic [WIDTH-1:0] M_div_src1,
  input  logic [WIDTH-1:0] M_div_src2,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quotient,
  output logic [WIDTH-1:0] M_div_remainder,
  output logic             M_div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's complement negate.
  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Magnitude of v when it is treated as signed, otherwise v unchanged.
  // The most negative value maps to itself. That is still the correct
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v,
                                             input logic              sgn);
    return (sgn && v[WIDTH-1]) ? neg_f(v) : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder, always < divisor
  logic [WIDTH-1:0]   dvd_q;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
  logic [WIDTH-1:0]   raw1_q;     // unmodified dividend for the by-zero result
  logic               s1_neg_q;   // signed op with negative dividend
  logic               s2_neg_q;   // signed op with negative divisor
  logic               zero_q;     // divisor was zero
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   remd_q;
  logic               by_zero_q;
  logic               busy_q;
  logic               done_q;

  logic               start_acc_d;
  logic               src2_zero_d;
  logic [WIDTH:0]     sh_rem_d;   // WIDTH+1 bits so the compare cannot overflow
  logic               ge_d;
  logic [WIDTH-1:0]   rem_step_d;
  logic [WIDTH-1:0]   dvd_step_d;
  logic [WIDTH-1:0]   q_fix_d;
  logic [WIDTH-1:0]   r_fix_d;

  assign start_acc_d = (state_q == S_IDLE) && M_div_start;
  assign src2_zero_d = (M_div_src2 == '0);

  // Next-state logic for the divider sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (M_div_start) begin
`ifdef NIOS_DIV_CELL_ZERO_FASTPATH_EN
          if (src2_zero_d) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit and subtract if possible.
  always_comb begin
    sh_rem_d = {rem_q, dvd_q[WIDTH-1]};
    ge_d     = (sh_rem_d >= {1'b0, dvs_q});
    if (ge_d) begin
      // The true difference is below the divisor, so WIDTH bits hold it exactly.
      rem_step_d = sh_rem_d[WIDTH-1:0] - dvs_q;
    end else begin
      rem_step_d = sh_rem_d[WIDTH-1:0];
    end
    dvd_step_d = {dvd_q[WIDTH-2:0], ge_d};
  end

  // Sign correction and forced divide-by-zero results.
  always_comb begin
    if (zero_q) begin
      q_fix_d = '1;
      r_fix_d = raw1_q;
    end else begin
      q_fix_d = (s1_neg_q ^ s2_neg_q) ? neg_f(dvd_q) : dvd_q;
      r_fix_d = s1_neg_q ? neg_f(rem_q) : rem_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      raw1_q    <= '0;
      s1_neg_q  <= 1'b0;
      s2_neg_q  <= 1'b0;
      zero_q    <= 1'b0;
      quot_q    <= '0;
      remd_q    <= '0;
      by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc_d) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= abs_f(M_div_src1, M_div_signed);
            dvs_q     <= abs_f(M_div_src2, M_div_signed);
            raw1_q    <= M_div_src1;
            s1_neg_q  <= M_div_signed & M_div_src1[WIDTH-1];
            s2_neg_q  <= M_div_signed & M_div_src2[WIDTH-1];
            zero_q    <= src2_zero_d;
`ifdef NIOS_DIV_CELL_ZERO_FASTPATH_EN
            // The fast path never visits FIX, so its results are written here.
            if (src2_zero_d) begin
              quot_q    <= '1;
              remd_q    <= M_div_src1;
              by_zero_q <= 1'b1;
            end else begin
              by_zero_q <= 1'b0;
            end
`else
            by_zero_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q;
          end
        end
        S_RUN: begin
          rem_q <= rem_step_d;
          dvd_q <= dvd_step_d;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          quot_q    <= q_fix_d;
          remd_q    <= r_fix_d;
          by_zero_q <= zero_q;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // Registered handshake. busy covers RUN..DONE delayed by one cycle, so it
  // rises on the edge after acceptance and falls together with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_q != S_IDLE);
      done_q <= (state_q == S_DONE);
    end
  end

  assign M_div_busy      = busy_q;
  assign M_div_done      = done_q;
  assign M_div_quotient  = quot_q;
  assign M_div_remainder = remd_q;
  assign M_div_by_zero   = by_zero_q;

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// Self-checking bench for nios_cpu_div_cell (WIDTH=32). Expected results come
// from a small integer model and are queued when each start is driven. They
// are popped and compared when the done pulse is seen.
module tb_nios_cpu_div_cell;

  localparam int W = 32;
  localparam int EXP_LAT = W + 2;
`ifdef NIOS_DIV_CELL_ZERO_FASTPATH_EN
  localparam int ZERO_LAT  = 1;
  localparam int ZERO_BUSY = 1;
`else
  localparam int ZERO_LAT  = W + 2;
  localparam int ZERO_BUSY = W + 2;
`endif
  localparam int WINDOW = 40;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         busy, done, by_zero;
  logic [W-1:0] quot, remd;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Values captured by do_div.
  logic [W-1:0] got_q, got_r;
  logic         got_z;
  int           lat, busy_n, done_n;
  logic         snap_busy, snap_done, snap_z;
  logic [W-1:0] snap_q, snap_r;

  nios_cpu_div_cell #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .M_div_start(start), .M_div_signed(sgn),
    .M_div_src1(src1), .M_div_src2(src2), .M_div_busy(busy), .M_div_done(done),
    .M_div_quotient(quot), .M_div_remainder(remd), .M_div_by_zero(by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sb_i;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'h0; e.z = 1'b0;
    end else if (s) begin
      sa = a; sb_i = b;
      e.q = sa / sb_i; e.r = sa % sb_i; e.z = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  // act: 0 none, 1 re-pulse start with 50/5 at act_edge, 2 reset at act_edge.
  task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int act, input int act_edge);
    @(negedge clk);
    start = 1'b1; sgn = s; src1 = a; src2 = b;
    if (act != 2) sb.push_back(model(s, a, b));
    @(negedge clk);           // edge 0 has sampled the start
    start = 1'b0;
    lat = -1; busy_n = 0; done_n = 0;
    for (int n = 1; n <= WINDOW; n++) begin
      if (act == 1 && n == act_edge) begin
        start = 1'b1; sgn = 1'b0; src1 = 32'd50; src2 = 32'd5;
      end
      if (act == 2 && n == act_edge) reset = 1'b1;
      @(negedge clk);         // just after edge n
      start = 1'b0;
      if (act == 2 && n == act_edge) begin
        snap_busy = busy; snap_done = done; snap_q = quot; snap_r = remd; snap_z = by_zero;
        reset = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = n; got_q = quot; got_r = remd; got_z = by_zero;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quot !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", quot); end
    checks++; if (remd !== 32'h0) begin errors++; $display("FAIL reset_r: got %h expected 0", remd); end
    checks++; if (by_zero !== 1'b0) begin errors++; $display("FAIL reset_z: got %b expected 0", by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    exp_t e;
    do_div(1'b0, 32'd100, 32'd7, 0, 0);
    e = sb.pop_front();
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL u_lat: got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (busy_n != EXP_LAT) begin errors++; $display("FAIL u_busy: got %0d expected %0d", busy_n, EXP_LAT); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL u_done_n: got %0d expected 1", done_n); end
    checks++; if (got_q !== 32'd14 || got_q !== e.q) begin errors++; $display("FAIL u_q: got %h expected %h", got_q, e.q); end
    checks++; if (got_r !== 32'd2 || got_r !== e.r) begin errors++; $display("FAIL u_r: got %h expected %h", got_r, e.r); end
    checks++; if (got_z !== e.z) begin errors++; $display("FAIL u_z: got %b expected %b", got_z, e.z); end
  endtask

  task automatic test_signed();
    logic [W-1:0] a_t[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] b_t[4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic         s_t[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      do_div(s_t[i], a_t[i], b_t[i], 0, 0);
      e = sb.pop_front();
      checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL s%0d_lat: got %0d expected %0d", i, lat, EXP_LAT); end
      checks++; if (got_q !== e.q) begin errors++; $display("FAIL s%0d_q: got %h expected %h", i, got_q, e.q); end
      checks++; if (got_r !== e.r) begin errors++; $display("FAIL s%0d_r: got %h expected %h", i, got_r, e.r); end
      checks++; if (got_z !== 1'b0) begin errors++; $display("FAIL s%0d_z: got %b expected 0", i, got_z); end
    end
  endtask

  task automatic test_by_zero();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      do_div(i == 0, 32'h1234_5678, 32'h0, 0, 0);
      e = sb.pop_front();
      checks++; if (lat != ZERO_LAT) begin errors++; $display("FAIL z%0d_lat: got %0d expected %0d", i, lat, ZERO_LAT); end
      checks++; if (busy_n != ZERO_BUSY) begin errors++; $display("FAIL z%0d_busy: got %0d expected %0d", i, busy_n, ZERO_BUSY); end
      checks++; if (got_q !== 32'hFFFF_FFFF || got_q !== e.q) begin errors++; $display("FAIL z%0d_q: got %h expected %h", i, got_q, e.q); end
      checks++; if (got_r !== 32'h1234_5678 || got_r !== e.r) begin errors++; $display("FAIL z%0d_r: got %h expected %h", i, got_r, e.r); end
      checks++; if (got_z !== 1'b1) begin errors++; $display("FAIL z%0d_flag: got %b expected 1", i, got_z); end
    end
    do_div(1'b0, 32'd9, 32'd3, 0, 0);
    e = sb.pop_front();
    checks++; if (got_z !== 1'b0) begin errors++; $display("FAIL z_clear: got %b expected 0", got_z); end
    checks++; if (got_q !== e.q || got_r !== e.r) begin errors++; $display("FAIL z_after: got %h/%h expected %h/%h", got_q, got_r, e.q, e.r); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_div(1'b0, 32'd100, 32'd7, 1, 10);
    e = sb.pop_front();
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL b2b_lat: got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL b2b_done_n: got %0d expected 1", done_n); end
    checks++; if (got_q !== e.q || got_r !== e.r) begin errors++; $display("FAIL b2b_res: got %h/%h expected %h/%h", got_q, got_r, e.q, e.r); end
    repeat (5) @(negedge clk);
    checks++; if (quot !== e.q || remd !== e.r || busy !== 1'b0) begin
      errors++; $display("FAIL hold: got q=%h r=%h busy=%b expected q=%h r=%h busy=0", quot, remd, busy, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_div(1'b0, 32'd100, 32'd7, 2, 15);
    checks++; if (snap_busy !== 1'b0 || snap_done !== 1'b0) begin errors++; $display("FAIL rm_ctl: got busy=%b done=%b expected 0 0", snap_busy, snap_done); end
    checks++; if (snap_q !== 32'h0 || snap_r !== 32'h0 || snap_z !== 1'b0) begin errors++; $display("FAIL rm_out: got %h/%h/%b expected 0", snap_q, snap_r, snap_z); end
    checks++; if (done_n != 0) begin errors++; $display("FAIL rm_no_done: got %0d expected 0", done_n); end
    do_div(1'b0, 32'd20, 32'd6, 0, 0);
    e = sb.pop_front();
    checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rm_lat: got %0d expected %0d", lat, EXP_LAT); end
    checks++; if (got_q !== 32'd3 || got_r !== 32'd2 || got_q !== e.q) begin errors++; $display("FAIL rm_res: got %h/%h expected 3/2", got_q, got_r); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : $urandom();
      if (b == '0) b = 32'd1;
      if (i % 3 == 0) b = ~b + 32'd1;
      s = i[0] ^ i[1];
      do_div(s, a, b, 0, 0);
      e = sb.pop_front();
      checks++; if (got_q !== e.q || got_r !== e.r || got_z !== e.z) begin
        errors++; $display("FAIL rnd%0d: s=%b %h/%h got %h/%h expected %h/%h", i, s, a, b, got_q, got_r, e.q, e.r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_by_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_cpu_div_cell.md
Name: nios_cpu_div_cell

Overview:
- Iterative radix-2 integer divider cell for the Nios CPU datapath. It is the inverse-operation counterpart of the pipelined 16x16-split multiply cell.
- Accepts a dividend/divisor pair with a start pulse and produces quotient and remainder after a fixed multi-cycle latency.
- Signals completion with a one-cycle done pulse.
- Sits beside the multiply cell in the M stage. The CPU stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits; even, >= 4
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
M_div_start  input  1  request pulse; sampled only while idle
M_div_signed  input  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
M_div_src1  input  WIDTH  dividend; sampled with start
M_div_src2  input  WIDTH  divisor; sampled with start
M_div_busy  output  1  high from the edge after start acceptance until done deasserts
M_div_done  output  1  one-cycle completion pulse
M_div_quotient  output  WIDTH  quotient; valid from done, held until next accepted start
M_div_remainder  output  WIDTH  remainder; same validity as quotient
M_div_by_zero  output  1  divisor was zero; same validity as quotient

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE. busy, done and by_zero are 0; quotient and remainder are 0; counter is 0.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: start=1 latches the operands, signed flag and sign bits. It loads abs(src1) and abs(src2); abs applies only when signed=1, otherwise the raw values are loaded. Remainder accumulator is cleared, counter=0, next state RUN.
  - RUN: one restoring step per cycle. Shift {rem,dvd} left by 1; if rem >= divisor, subtract and set the quotient LSB to 1, else set it to 0. Counter increments; after WIDTH steps go to FIX.
  - FIX: apply sign correction. Quotient is negated when signed and the sign of src1 differs from the sign of src2. Remainder is negated when signed and src1 was negative. Division truncates toward zero. Next state DONE.
  - DONE: done=1 for exactly one cycle, results registered, next state IDLE.
- Internal remainder is WIDTH+1 bits so the compare/subtract never overflows.
- busy=1 in RUN, FIX and DONE.
- Latency: start is sampled at edge k and done is high in the cycle following edge k+WIDTH+2 (edge 34 for WIDTH=32).
- start while busy is ignored; no queueing and no error.
- Outputs hold their last result through IDLE until the FIX of the next accepted operation overwrites them.
- Signed overflow: -2^(WIDTH-1) / -1 gives quotient=0x80000000 and remainder=0, with no flag.
- Divisor zero:
  - by_zero=1; quotient is forced to all ones and remainder to the raw src1, in both signed and unsigned modes.
  - by_zero clears on the next accepted start.
- reset mid-operation returns to IDLE on the next edge. No done is produced, and outputs are zero.
- Simultaneous reset and start: reset wins.

Optional Feature:
NIOS_DIV_CELL_ZERO_FASTPATH_EN
- Defined: in IDLE, start with src2==0 goes directly to DONE with the forced by-zero results. done is high in the cycle after edge k+1 and busy is high for that single cycle.
- Undefined: divide-by-zero takes the full WIDTH+2 latency like any other operation, with the same forced results.

Test Plan:
- Unsigned 100/7, start at edge 0 -> done only in the cycle after edge 34; q=14, r=2, by_zero=0; busy high for exactly 34 cycles.
- Signed 0xFFFFFFF9 / 2 (-7/2) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Then 7/-2 -> q=0xFFFFFFFD, r=1.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned on the same operands -> q=0, r=0x80000000.
- 0x12345678/0, signed and unsigned -> q=0xFFFFFFFF, r=0x12345678, by_zero=1.
  - Done timing: edge 34, or edge 1 with NIOS_DIV_CELL_ZERO_FASTPATH_EN defined.
  - A following 9/3 -> by_zero=0, q=3, r=0.
- Start 100/7, re-pulse start with 50/5 at edge 10 -> ignored; result q=14, r=2 at edge 34; results hold through 5 idle cycles.
- Start 100/7, assert reset at edge 15 for one cycle -> IDLE, busy=0, outputs 0, no done pulse. A new 20/6 start afterwards -> q=3, r=2 after full latency.
